// File: rtl/lv_owt_req_agent.sv
// LV-side register request agent for the one-wire transfer link.
// Frames spi_owt requests for the HV die and returns ack or read data.
module lv_owt_req_agent #(
    parameter int                REG_AW      = 7,
    parameter int                REG_DW      = 8,
    parameter int                TIMEOUT_CYC = 255,
    parameter int                MAX_RETRY   = 2,
    parameter logic [REG_DW-1:0] ERR_RDATA   = 8'hFF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_spi_owt_wr_req,
    input  logic                     i_spi_owt_rd_req,
    input  logic [REG_AW-1:0]        i_spi_owt_addr,
    input  logic [REG_DW-1:0]        i_spi_owt_data,
    output logic                     o_owt_tx_spi_ack,
    output logic                     o_hv_reg_vld,
    output logic [REG_DW-1:0]        o_hv_ang_reg_data,
    output logic                     o_owt_tx_vld,
    output logic [REG_AW+REG_DW:0]   o_owt_tx_frame,
    input  logic                     i_owt_tx_rdy,
    input  logic                     i_owt_tx_done,
    input  logic                     i_owt_rx_vld,
    input  logic [REG_AW-1:0]        i_owt_rx_addr,
    input  logic [REG_DW-1:0]        i_owt_rx_data,
    input  logic                     i_owt_rx_crc_ok,
    output logic                     o_owt_err,
    output logic                     o_owt_busy
);

    localparam int FW = 1 + REG_AW + REG_DW;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_RSP,
        RETRY,
        ACK,
        DROP
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     frame_q;
    logic [TW-1:0]     tmr_q;
    logic [RW-1:0]     rty_q;
    logic [REG_DW-1:0] rdata_q;
    logic              err_q;

    logic              latch;
    logic              tmr_clr;
    logic              rty_inc;
    logic              cap;
    logic              fail;
    logic              rw;
    logic [REG_AW-1:0] addr;

    assign rw   = frame_q[FW-1];
    assign addr = frame_q[FW-2 -: REG_AW];

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        tmr_clr = 1'b0;
        rty_inc = 1'b0;
        cap     = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_spi_owt_wr_req || i_spi_owt_rd_req) begin
                    latch   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (i_owt_tx_rdy) begin
                    tmr_clr = 1'b1;
                    state_d = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (i_owt_tx_done) begin
                    tmr_clr = 1'b1;
                    state_d = rw ? ACK : WAIT_RSP;
                end else if (tmr_q == TMAX) begin
                    state_d = RETRY;
                end
            end
            WAIT_RSP: begin
                // A response beats a same-cycle timeout.
                if (i_owt_rx_vld) begin
                    if (i_owt_rx_crc_ok && (i_owt_rx_addr == addr)) begin
                        cap     = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = RETRY;
                    end
                end else if (tmr_q == TMAX) begin
                    state_d = RETRY;
                end
            end
            RETRY: begin
                if (rty_q < RMAX) begin
                    rty_inc = 1'b1;
                    state_d = SEND;
                end else begin
                    fail    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = DROP;
            end
            DROP: begin
                if (!i_spi_owt_wr_req && !i_spi_owt_rd_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            tmr_q   <= '0;
            rty_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= fail;
            // Write wins when both requests are raised together.
            if (latch) begin
                if (i_spi_owt_wr_req) begin
                    frame_q <= {1'b1, i_spi_owt_addr, i_spi_owt_data};
                end else begin
                    frame_q <= {1'b0, i_spi_owt_addr, {REG_DW{1'b0}}};
                end
            end
            if (latch) begin
                rty_q <= '0;
            end else if (rty_inc) begin
                rty_q <= rty_q + 1'b1;
            end
            if (tmr_clr) begin
                tmr_q <= '0;
            end else if ((state_q == WAIT_TX || state_q == WAIT_RSP) &&
                         (tmr_q != {TW{1'b1}})) begin
                tmr_q <= tmr_q + 1'b1;
            end
            if (cap) begin
                rdata_q <= i_owt_rx_data;
            end else if (fail && !rw) begin
                rdata_q <= ERR_RDATA;
            end
        end
    end

    assign o_owt_tx_vld      = (state_q == SEND);
    assign o_owt_tx_frame    = frame_q;
    assign o_owt_tx_spi_ack  = (state_q == ACK) && rw;
    assign o_hv_reg_vld      = (state_q == ACK) && !rw;
    assign o_hv_ang_reg_data = rdata_q;
    assign o_owt_err         = err_q;
    assign o_owt_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lv_owt_req_agent.sv
// Scoreboard bench for lv_owt_req_agent with a small OWT link model.
module tb_lv_owt_req_agent;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_spi_owt_wr_req;
    logic        i_spi_owt_rd_req;
    logic [6:0]  i_spi_owt_addr;
    logic [7:0]  i_spi_owt_data;
    logic        o_owt_tx_spi_ack;
    logic        o_hv_reg_vld;
    logic [7:0]  o_hv_ang_reg_data;
    logic        o_owt_tx_vld;
    logic [15:0] o_owt_tx_frame;
    logic        i_owt_tx_rdy;
    logic        i_owt_tx_done;
    logic        i_owt_rx_vld;
    logic [6:0]  i_owt_rx_addr;
    logic [7:0]  i_owt_rx_data;
    logic        i_owt_rx_crc_ok;
    logic        o_owt_err;
    logic        o_owt_busy;

    lv_owt_req_agent dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_spi_owt_wr_req  (i_spi_owt_wr_req),
        .i_spi_owt_rd_req  (i_spi_owt_rd_req),
        .i_spi_owt_addr    (i_spi_owt_addr),
        .i_spi_owt_data    (i_spi_owt_data),
        .o_owt_tx_spi_ack  (o_owt_tx_spi_ack),
        .o_hv_reg_vld      (o_hv_reg_vld),
        .o_hv_ang_reg_data (o_hv_ang_reg_data),
        .o_owt_tx_vld      (o_owt_tx_vld),
        .o_owt_tx_frame    (o_owt_tx_frame),
        .i_owt_tx_rdy      (i_owt_tx_rdy),
        .i_owt_tx_done     (i_owt_tx_done),
        .i_owt_rx_vld      (i_owt_rx_vld),
        .i_owt_rx_addr     (i_owt_rx_addr),
        .i_owt_rx_data     (i_owt_rx_data),
        .i_owt_rx_crc_ok   (i_owt_rx_crc_ok),
        .o_owt_err         (o_owt_err),
        .o_owt_busy        (o_owt_busy)
    );

    typedef struct {
        logic       ack;
        logic       vld;
        logic       err;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        int         kind;   // 0 none, 1 good, 2 bad crc, 3 wrong addr
        logic [7:0] data;
    } rsp_t;

    ev_t         exp_ev[$];
    logic [15:0] exp_frame[$];
    rsp_t        rsp_q[$];

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int done_cyc = 0;
    int tx_delay = 10;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Transmitter/receiver model: shifts a frame, answers reads from rsp_q.
    initial begin
        logic [15:0] f;
        rsp_t        r;
        forever begin
            @(negedge i_clk);
            if (o_owt_tx_vld && i_owt_tx_rdy) begin
                f = o_owt_tx_frame;
                repeat (tx_delay) @(negedge i_clk);
                i_owt_tx_done = 1'b1;
                done_cyc = cyc;
                @(negedge i_clk);
                i_owt_tx_done = 1'b0;
                if (!f[15] && rsp_q.size() > 0) begin
                    r = rsp_q.pop_front();
                    if (r.kind != 0) begin
                        repeat (2) @(negedge i_clk);
                        i_owt_rx_vld    = 1'b1;
                        i_owt_rx_addr   = (r.kind == 3) ? (f[14:8] ^ 7'h01) : f[14:8];
                        i_owt_rx_data   = r.data;
                        i_owt_rx_crc_ok = (r.kind != 2);
                        @(negedge i_clk);
                        i_owt_rx_vld    = 1'b0;
                        i_owt_rx_crc_ok = 1'b0;
                    end
                end
            end
        end
    end

    // Frame monitor.
    initial forever begin
        @(negedge i_clk);
        if (o_owt_tx_vld && i_owt_tx_rdy) begin
            if (exp_frame.size() == 0) begin
                chk("unexpected_frame", {16'h0, o_owt_tx_frame}, 32'hDEAD);
            end else begin
                chk("tx_frame", {16'h0, o_owt_tx_frame}, {16'h0, exp_frame.pop_front()});
            end
        end
    end

    // Response monitor.
    initial begin
        ev_t e;
        forever begin
            @(negedge i_clk);
            if (o_owt_tx_spi_ack || o_hv_reg_vld || o_owt_err) begin
                if (exp_ev.size() == 0) begin
                    chk("unexpected_event",
                        {29'h0, o_owt_tx_spi_ack, o_hv_reg_vld, o_owt_err}, 32'h0);
                end else begin
                    e = exp_ev.pop_front();
                    chk("event_flags",
                        {29'h0, o_owt_tx_spi_ack, o_hv_reg_vld, o_owt_err},
                        {29'h0, e.ack, e.vld, e.err});
                    if (e.vld) chk("read_data", {24'h0, o_hv_ang_reg_data}, {24'h0, e.data});
                    if (e.ack) chk("ack_latency", cyc, done_cyc + 1);
                end
            end
        end
    end

    task automatic push_ev(input logic ack, input logic vld, input logic err,
                           input logic [7:0] data);
        ev_t e;
        e.ack = ack;
        e.vld = vld;
        e.err = err;
        e.data = data;
        exp_ev.push_back(e);
    endtask

    task automatic push_rsp(input int kind, input logic [7:0] data);
        rsp_t r;
        r.kind = kind;
        r.data = data;
        rsp_q.push_back(r);
    endtask

    task automatic do_req(input logic wr, input logic rd, input logic [6:0] a,
                          input logic [7:0] d, input int hold);
        bit seen = 0;
        @(negedge i_clk);
        i_spi_owt_wr_req = wr;
        i_spi_owt_rd_req = rd;
        i_spi_owt_addr   = a;
        i_spi_owt_data   = d;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge i_clk);
            i_spi_owt_addr = ~a;
            i_spi_owt_data = ~d;
            if (o_owt_tx_spi_ack || o_hv_reg_vld) seen = 1;
        end
        if (!seen) chk("req_timeout", 32'h0, 32'h1);
        repeat (hold) @(negedge i_clk);
        if (hold > 0) chk("busy_in_drop", {31'h0, o_owt_busy}, 32'h1);
        i_spi_owt_wr_req = 1'b0;
        i_spi_owt_rd_req = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    initial begin
        i_rst_n          = 1'b0;
        i_spi_owt_wr_req = 1'b0;
        i_spi_owt_rd_req = 1'b0;
        i_spi_owt_addr   = '0;
        i_spi_owt_data   = '0;
        i_owt_tx_rdy     = 1'b1;
        i_owt_tx_done    = 1'b0;
        i_owt_rx_vld     = 1'b0;
        i_owt_rx_addr    = '0;
        i_owt_rx_data    = '0;
        i_owt_rx_crc_ok  = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("reset_outputs",
            {5'h0, o_owt_tx_spi_ack, o_hv_reg_vld, o_owt_tx_vld,
             o_owt_err, o_owt_busy, o_hv_ang_reg_data, o_owt_tx_frame}, 32'h0);
        i_rst_n = 1'b1;

        // write 0x06 <= 0xA5
        exp_frame.push_back(16'h86A5);
        push_ev(1, 0, 0, 8'h00);
        do_req(1, 0, 7'h06, 8'hA5, 0);

        // read 0x14, good response
        exp_frame.push_back(16'h1400);
        push_rsp(1, 8'h3C);
        push_ev(0, 1, 0, 8'h3C);
        do_req(0, 1, 7'h14, 8'h99, 0);
        repeat (5) @(negedge i_clk);
        chk("rdata_held", {24'h0, o_hv_ang_reg_data}, 32'h3C);
        chk("idle_after_read", {31'h0, o_owt_busy}, 32'h0);

        // read 0x33, bad crc then good
        exp_frame.push_back(16'h3300);
        exp_frame.push_back(16'h3300);
        push_rsp(2, 8'hEE);
        push_rsp(1, 8'h5A);
        push_ev(0, 1, 0, 8'h5A);
        do_req(0, 1, 7'h33, 8'h00, 0);

        // read 0x05, wrong echoed address then good
        exp_frame.push_back(16'h0500);
        exp_frame.push_back(16'h0500);
        push_rsp(3, 8'h22);
        push_rsp(1, 8'h11);
        push_ev(0, 1, 0, 8'h11);
        do_req(0, 1, 7'h05, 8'h00, 0);

        // read 0x7F, no response: three frames, then error
        repeat (3) exp_frame.push_back(16'h7F00);
        push_ev(0, 1, 1, 8'hFF);
        do_req(0, 1, 7'h7F, 8'h00, 0);

        // write held 20 cycles after ack
        exp_frame.push_back(16'hC012);
        push_ev(1, 0, 0, 8'h00);
        do_req(1, 0, 7'h40, 8'h12, 20);
        chk("idle_after_drop", {31'h0, o_owt_busy}, 32'h0);

        // both requests high: write wins
        exp_frame.push_back(16'hAA77);
        push_ev(1, 0, 0, 8'h00);
        do_req(1, 1, 7'h2A, 8'h77, 3);

        // reset in WAIT_RSP
        exp_frame.push_back(16'h1100);
        push_rsp(0, 8'h00);
        @(negedge i_clk);
        i_spi_owt_rd_req = 1'b1;
        i_spi_owt_addr   = 7'h11;
        repeat (25) @(negedge i_clk);
        chk("busy_before_reset", {31'h0, o_owt_busy}, 32'h1);
        i_rst_n          = 1'b0;
        i_spi_owt_rd_req = 1'b0;
        @(negedge i_clk);
        chk("midreset_outputs",
            {5'h0, o_owt_tx_spi_ack, o_hv_reg_vld, o_owt_tx_vld,
             o_owt_err, o_owt_busy, o_hv_ang_reg_data, o_owt_tx_frame}, 32'h0);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);

        exp_frame.push_back(16'h8102);
        push_ev(1, 0, 0, 8'h00);
        do_req(1, 0, 7'h01, 8'h02, 0);

        repeat (5) @(negedge i_clk);
        chk("frames_left", exp_frame.size(), 0);
        chk("events_left", exp_ev.size(), 0);
        chk("responses_left", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
